trap_ctrl: RTL
==============

# trap_ctrl

Trap and interrupt sequencer that sits directly upstream of the machine CSR unit. It synchronizes and latches NSRC asynchronous external interrupt lines and applies priority and enable gating. It waits for a clean instruction boundary, then drives the CSR unit's trap-entry, mret and interrupt-pending/acknowledge inputs, and drives the core's PC-redirect and flush. It also handles ecall as a synchronous exception and sequences mret back to mepc.

## Interface
- NSRC, 4, number of external interrupt sources; index 0 has the highest priority
- SYNC_STAGES, 2, synchronizer flops per source (minimum 2)
- clk  in  1  core clock
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- ext_irq  in  NSRC  asynchronous level interrupt requests
- mstatus_mie  in  1  mstatus[3] from the CSR unit
- mie_meie  in  1  mie[11] from the CSR unit
- mtvec  in  32  trap vector from the CSR unit
- mepc  in  32  saved PC from the CSR unit
- commit_valid  in  1  an instruction is at the commit point this cycle
- commit_pc  in  32  PC of that instruction
- commit_stall  in  1  commit point is stalled; no boundary is taken
- commit_ecall  in  1  committing instruction is ecall
- commit_mret  in  1  committing instruction is mret
- intr  out  1  one-cycle pulse to the CSR unit; sets mip[11]
- cu_intr_ack  out  1  one-cycle pulse at interrupt entry; clears mip[11]
- trap_set  out  1  one-cycle trap-entry strobe
- trap_cause  out  32  mcause value, valid while trap_set is high
- trap_pc  out  32  mepc value, valid while trap_set is high
- mret  out  1  one-cycle mret strobe to the CSR unit
- redirect  out  1  one-cycle PC redirect plus pipeline flush
- redirect_pc  out  32  target PC, valid while redirect is high
- irq_id  out  clog2(NSRC)  ID of the source claimed at the last entry
- in_handler  out  1  high while state is SERVICE
- nest_err  out  1  sticky flag: ecall seen in SERVICE

## Operation
- **Per-source input path:** SYNC_STAGES synchronizer, then a rising-edge detector, then a pending flop.
  - pend[i] sets on a synchronized rising edge.
  - pend[i] clears only when source i is claimed.
  - If a set and a claim of the same source fall in the same cycle, the set wins.
- **intr:** pulses for one cycle whenever any pend bit goes from 0 to 1.
- **Interrupt eligibility:** irq_ok = (|pend) & mstatus_mie & mie_meie.
- **Boundary:** boundary = commit_valid & !commit_stall.
- **States:** IDLE, DRAIN, ENTER, SERVICE.
- **IDLE:**
  - boundary & commit_ecall goes to ENTER as an exception. The exception has priority over a simultaneous irq_ok.
  - Otherwise irq_ok goes to DRAIN.
  - commit_mret in IDLE is ignored.
- **DRAIN:**
  - If irq_ok drops, go back to IDLE with no side effects.
  - Otherwise, on boundary, go to ENTER.
- **ENTER (one cycle):**
  - Assert trap_set, redirect and flush; redirect_pc = {mtvec[31:2], 2'b00}.
  - Interrupt: trap_pc = PC latched at the boundary (that instruction has not executed). trap_cause = 32'h8000000B. Claim the lowest-index pending source, set irq_id to it, pulse cu_intr_ack.
  - Exception: trap_pc = PC of the ecall. trap_cause = 32'h0000000B. No claim.
  - Next state is SERVICE.
- **SERVICE:**
  - boundary & commit_mret: pulse mret and redirect with redirect_pc = mepc, then go to IDLE.
  - Interrupts are not taken; no nesting.
  - boundary & commit_ecall sets nest_err and is otherwise ignored.
- **Reset:** all state is cleared, including synchronizers and pend, and the FSM goes to IDLE.

## Timing
- **Reset values:** all outputs 0, irq_id 0, state IDLE.
- **Input latency:** an ext_irq rise sampled at edge k gives pend and intr high after edge k+SYNC_STAGES+1.
- **DRAIN entry:** the earliest is one cycle after pend rises, if enabled.
- **ENTER:** one cycle after the qualifying boundary cycle. The boundary PC and cause are registered in that boundary cycle.
- **Strobes:** trap_set, redirect, cu_intr_ack and mret are single-cycle. They are never high in two consecutive cycles.
- **mret:** the mret pulse and its redirect occur one cycle after the mret boundary.
- **Back-to-back interrupts:** after mret, the next pending interrupt can enter DRAIN on the cycle after the return to IDLE.
- **mstatus_mie during SERVICE:** it is 0 while in SERVICE because the CSR unit clears it on trap_set. trap_ctrl does not depend on this.
- **Mid-operation reset:** reset asserted in any state forces IDLE asynchronously. No strobe is emitted on release.

## Structure
- Shared package trap_pkg holds:
  - the state enum;
  - the cause constants CAUSE_MEI = 32'h8000000B and CAUSE_ECALL_M = 32'h0000000B.
- Sub-module irq_sync_edge is instantiated once per source and contains the synchronizer, edge detector and pending flop.
  - Inputs: clk, reset, async_in, claim.
  - Outputs: pend, rise.

## Test plan
- **Single interrupt:** mie and meie set; ext_irq[2] rises; commit_valid is high every cycle with commit_pc=0x100.
  - intr at k+3.
  - trap_set with trap_pc=0x100 and trap_cause=0x8000000B.
  - redirect_pc equals mtvec with bits[1:0] cleared.
  - cu_intr_ack, irq_id=2, pend[2] cleared.
- **Priority:** ext_irq[3] and ext_irq[1] rise together. Entry claims 1; after mret, a second entry claims 3.
- **Ecall vs interrupt:** ecall at 0x200 on the same boundary as irq_ok.
  - Cause 0x0000000B and trap_pc=0x200.
  - pend is unchanged, no cu_intr_ack, and the interrupt is taken after mret.
- **Drain abort and stall:**
  - commit_stall is held for 5 cycles during DRAIN: no trap_set until the stall drops.
  - Clearing mie_meie during DRAIN returns the FSM to IDLE with no strobes.
- **mret and nesting:**
  - In SERVICE, an ecall sets nest_err.
  - mret with mepc=0x104 gives an mret pulse and redirect_pc=0x104, then IDLE.
  - A new interrupt raised during SERVICE is taken only after mret.
- **Reset mid-operation:** reset asserted in ENTER or SERVICE clears all outputs and pend immediately. After release the FSM is idle with no spurious strobes.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap sequencer: FSM state encoding and mcause values.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ENTER,
    ST_SERVICE
  } trap_state_t;

  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ECALL_M = 32'h0000_000B;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: synchronizer, registered rising-edge detector, pending flop.
// A rise sampled at edge k shows on pend after edge k+SYNC_STAGES+1; a set beats a same-cycle claim.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic claim,
  output logic pend,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_rise;
  logic                   r_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_last <= 1'b0;
      r_rise <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_last <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_last;
      r_pend <= r_rise | (r_pend & ~claim);
    end
  end

  assign pend = r_pend;
  assign rise = r_rise;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer in front of the machine CSR unit: waits for a commit boundary,
// then issues single-cycle trap-entry / mret strobes with PC redirect and flush.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC-1:0]         ext_irq,
  input  logic                    mstatus_mie,
  input  logic                    mie_meie,
  input  logic [31:0]             mtvec,
  input  logic [31:0]             mepc,
  input  logic                    commit_valid,
  input  logic [31:0]             commit_pc,
  input  logic                    commit_stall,
  input  logic                    commit_ecall,
  input  logic                    commit_mret,
  output logic                    intr,
  output logic                    cu_intr_ack,
  output logic                    trap_set,
  output logic [31:0]             trap_cause,
  output logic [31:0]             trap_pc,
  output logic                    mret,
  output logic                    redirect,
  output logic [31:0]             redirect_pc,
  output logic [$clog2(NSRC)-1:0] irq_id,
  output logic                    in_handler,
  output logic                    nest_err
);

  localparam int IDW = $clog2(NSRC);

  trap_state_t     r_state;
  trap_state_t     w_next;
  logic [NSRC-1:0] w_pend;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_claim;
  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  r_irq_id;
  logic [31:0]     r_pc;
  logic [31:0]     w_vec;
  logic            r_intr;
  logic            r_is_exc;
  logic            r_mret;
  logic            r_nest_err;
  logic            w_boundary;
  logic            w_irq_ok;
  logic            w_enter;
  logic            w_take_exc;
  logic            w_take_irq;
  logic            w_mret_bnd;
  logic            w_nest;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ext_irq[g]),
      .claim    (w_claim[g]),
      .pend     (w_pend[g]),
      .rise     (w_rise[g])
    );
  end

  assign w_boundary = commit_valid & ~commit_stall;
  assign w_irq_ok   = (|w_pend) & mstatus_mie & mie_meie;
  assign w_enter    = (r_state == ST_ENTER);
  assign w_vec      = mtvec & 32'hFFFF_FFFC;

  always_comb begin
    w_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_pend[i]) w_sel = IDW'(i);
    end
  end

  assign w_claim = (w_enter && !r_is_exc) ? (NSRC'(1) << w_sel) : '0;

  // An ecall commit in the cycle of an mret redirect is being flushed, so it cannot trap.
  always_comb begin
    w_next     = r_state;
    w_take_exc = 1'b0;
    w_take_irq = 1'b0;
    w_mret_bnd = 1'b0;
    w_nest     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_boundary && commit_ecall && !r_mret) begin
          w_next     = ST_ENTER;
          w_take_exc = 1'b1;
        end else if (w_irq_ok) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!w_irq_ok) begin
          w_next = ST_IDLE;
        end else if (w_boundary) begin
          w_next     = ST_ENTER;
          w_take_irq = 1'b1;
        end
      end
      ST_ENTER: w_next = ST_SERVICE;
      ST_SERVICE: begin
        if (w_boundary && commit_mret) begin
          w_next     = ST_IDLE;
          w_mret_bnd = 1'b1;
        end else if (w_boundary && commit_ecall) begin
          w_nest = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_intr     <= 1'b0;
      r_mret     <= 1'b0;
      r_pc       <= '0;
      r_is_exc   <= 1'b0;
      r_irq_id   <= '0;
      r_nest_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_intr  <= |(w_rise & ~w_pend);
      r_mret  <= w_mret_bnd;
      if (w_take_exc || w_take_irq) begin
        r_pc     <= commit_pc;
        r_is_exc <= w_take_exc;
      end
      if (w_enter && !r_is_exc) r_irq_id <= w_sel;
      if (w_nest) r_nest_err <= 1'b1;
    end
  end

  assign intr        = r_intr;
  assign trap_set    = w_enter;
  assign cu_intr_ack = w_enter & ~r_is_exc;
  assign trap_cause  = w_enter ? (r_is_exc ? CAUSE_ECALL_M : CAUSE_MEI) : '0;
  assign trap_pc     = w_enter ? r_pc : '0;
  assign mret        = r_mret;
  assign redirect    = w_enter | r_mret;
  assign redirect_pc = w_enter ? w_vec : (r_mret ? mepc : '0);
  assign irq_id      = r_irq_id;
  assign in_handler  = (r_state == ST_SERVICE);
  assign nest_err    = r_nest_err;

endmodule
